// File: rtl/wshb_fb_slave.sv
// Wishbone slave over a word-addressed frame-buffer memory: classic cycles with
// WAIT_STATES wait cycles, plus back-to-back incrementing bursts (cti=010/111).
// Optional macro WSHB_FB_ERR_EN: out-of-range addresses answer with err instead of wrapping.
module wshb_fb_slave #(
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] dat_ms,
  input  logic [3:0]  sel,
  input  logic [2:0]  cti,
  input  logic [1:0]  bte,
  output logic [31:0] dat_sm,
  output logic        ack,
  output logic        err
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, GAP} state_t;

  // Handshake: a request is cyc&stb; each accepted beat gets exactly one
  // registered ack (or err) cycle, read data valid in that same cycle.
  state_t        state;
  logic [3:0]    wait_cnt;
  logic [31:0]   mem [DEPTH];

  logic          req;
  logic [IW-1:0] bus_idx, lat_idx, op_idx;
  logic          bus_oor, lat_oor, op_oor;
  logic [31:0]   lat_dat, op_dat;
  logic [3:0]    lat_sel, op_sel;
  logic          lat_we, op_we;
  logic [2:0]    lat_cti;
  logic          err_q;
  logic          go_ack, do_write;
  logic          unused_ok;

  assign req     = cyc & stb;
  assign bus_idx = adr[IW+1:2];

`ifdef WSHB_FB_ERR_EN
  assign bus_oor   = |adr[31:IW+2];
  assign err       = err_q;
  assign unused_ok = ^{bte, adr[1:0]};
`else
  assign bus_oor   = 1'b0;
  assign err       = 1'b0;
  assign unused_ok = ^{bte, adr[1:0], adr[31:IW+2]};
`endif

  // The beat served by the next ACK cycle comes from the latch only when
  // leaving WAIT; zero-wait entries and burst continuations use the live bus.
  always_comb begin
    op_idx = (state == WAIT) ? lat_idx : bus_idx;
    op_oor = (state == WAIT) ? lat_oor : bus_oor;
    op_dat = (state == WAIT) ? lat_dat : dat_ms;
    op_sel = (state == WAIT) ? lat_sel : sel;
    op_we  = (state == WAIT) ? lat_we  : we;
    go_ack = 1'b0;
    unique case (state)
      IDLE, GAP: go_ack = req && (WAIT_STATES == 0);
      WAIT:      go_ack = req && (wait_cnt == WS_LAST);
      ACK:       go_ack = req && (lat_cti == 3'b010) && !err_q;
      default:   go_ack = 1'b0;
    endcase
    do_write = rst_n && go_ack && op_we && !op_oor;
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (op_sel[b]) mem[op_idx][8*b +: 8] <= op_dat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      ack      <= 1'b0;
      err_q    <= 1'b0;
      dat_sm   <= 32'd0;
      lat_idx  <= '0;
      lat_oor  <= 1'b0;
      lat_dat  <= 32'd0;
      lat_sel  <= 4'd0;
      lat_we   <= 1'b0;
      lat_cti  <= 3'd0;
    end else begin
      ack   <= 1'b0;
      err_q <= 1'b0;
      unique case (state)
        IDLE, GAP: begin
          if (req) begin
            lat_idx  <= bus_idx;
            lat_oor  <= bus_oor;
            lat_dat  <= dat_ms;
            lat_sel  <= sel;
            lat_we   <= we;
            lat_cti  <= cti;
            wait_cnt <= 4'd0;
            state    <= (WAIT_STATES == 0) ? ACK : WAIT;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (!req)                     state    <= IDLE;
          else if (wait_cnt == WS_LAST) state    <= ACK;
          else                          wait_cnt <= wait_cnt + 4'd1;
        end
        ACK: begin
          if (go_ack) begin
            lat_idx <= bus_idx;
            lat_oor <= bus_oor;
            lat_dat <= dat_ms;
            lat_sel <= sel;
            lat_we  <= we;
            lat_cti <= cti;
            state   <= ACK;
          end else begin
            state <= GAP;
          end
        end
        default: state <= IDLE;
      endcase
      if (go_ack) begin
        if (op_oor) begin
          err_q <= 1'b1;
        end else begin
          ack <= 1'b1;
          if (!op_we) dat_sm <= mem[op_idx];
        end
      end
    end
  end
endmodule

// File: tb/tb_wshb_fb_slave.sv
// Directed bench for wshb_fb_slave (DEPTH=4096, WAIT_STATES=1): drivers push the
// expected ack/err response into exp_q, a negedge monitor pops and compares.
module tb_wshb_fb_slave;
  localparam int W  = 34;  // {expect_err, check_data, data[31:0]}
  localparam int WS = 1;

  logic        clk, rst_n, cyc, stb, we, ack, err;
  logic [31:0] adr, dat_ms, dat_sm;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int vectors = 0;
  int miscompares = 0;

  wshb_fb_slave #(.DEPTH(4096), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n), .cyc(cyc), .stb(stb), .we(we), .adr(adr),
    .dat_ms(dat_ms), .sel(sel), .cti(cti), .bte(bte),
    .dat_sm(dat_sm), .ack(ack), .err(err)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && (ack || err)) begin
      vectors++;
      if (ack && err) begin
        miscompares++;
        $display("FAIL ack_err_together: got ack=%b err=%b expected one-hot", ack, err);
      end else if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_response: got ack=%b err=%b expected none", ack, err);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e[33] !== err) begin
          miscompares++;
          $display("FAIL response_kind: got err=%b expected err=%b", err, mon_e[33]);
        end else if (mon_e[32] && (dat_sm !== mon_e[31:0])) begin
          miscompares++;
          $display("FAIL read_data: got %h expected %h", dat_sm, mon_e[31:0]);
        end
      end
    end
  end

  // drivers
  task automatic idle_bus();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
  endtask

  task automatic single(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic exp_err, input logic [31:0] exp_d);
    int lat;
    exp_q.push_back({exp_err, ~w, w ? 32'd0 : exp_d});
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_ms = d; sel = s; cti = 3'b000;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(ack || err) && lat < 50);
    check("single_latency", 32'(lat), 32'(1 + WS));
    idle_bus();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    single(1'b1, a, d, s, 1'b0, 32'd0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] expd);
    single(1'b0, a, 32'd0, 4'hf, 1'b0, expd);
  endtask

  logic [31:0] burst_data [4];

  initial begin
    burst_data[0] = 32'h01234567;
    burst_data[1] = 32'h89ABCDEF;
    burst_data[2] = 32'hDEADBEEF;
    burst_data[3] = 32'h0BADF00D;

    // reset
    rst_n = 1'b0; adr = 32'd0; dat_ms = 32'd0; sel = 4'd0; bte = 2'd0;
    idle_bus();
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_dat_sm", dat_sm, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic write / read-back
    wr(32'h10, 32'hBABECAFE, 4'hf);
    rd(32'h10, 32'hBABECAFE);

    // byte enables, then an all-disabled write that must not change the word
    wr(32'h30, 32'h11223344, 4'hf);
    wr(32'h30, 32'hAABBCCDD, 4'b0101);
    rd(32'h30, 32'h11BB33DD);
    wr(32'h30, 32'hFFFFFFFF, 4'b0000);
    rd(32'h30, 32'h11BB33DD);

    // preload and burst read of four words
    for (int i = 0; i < 4; i++) wr(32'(i * 4), burst_data[i], 4'hf);
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 1'b1, burst_data[i]});
    begin
      int lat;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; sel = 4'hf; cti = 3'b010;
      lat = 0;
      do begin
        @(posedge clk); #1;
        lat++;
      end while (!ack && lat < 50);
      check("burst_first_latency", 32'(lat), 32'(1 + WS));
      for (int b = 1; b < 4; b++) begin
        adr = 32'(b * 4);
        cti = (b == 3) ? 3'b111 : 3'b010;
        @(posedge clk); #1;
        check("burst_beat_ack", 32'(ack), 32'd1);
      end
      idle_bus();
      @(posedge clk); #1;
      check("burst_gap", 32'(ack), 32'd0);
      @(posedge clk); #1;
    end

    // stb held with classic cycles: one ack every 2+WS cycles
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 1'b1, 32'hBABECAFE});
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10; sel = 4'hf; cti = 3'b000;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      check("continuous_ack_pattern", 32'(ack), ((k % 3) == 2) ? 32'd1 : 32'd0);
    end
    idle_bus();
    @(posedge clk); #1;

    // stb dropped during WAIT
    wr(32'h20, 32'h5A5A5A5A, 4'hf);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h20; dat_ms = 32'hFFFFFFFF; sel = 4'hf;
    @(posedge clk); #1;
    stb = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("abort_no_response", 32'({ack, err}), 32'd0);
    end
    idle_bus();

    // reset pulse during a write WAIT
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h20; dat_ms = 32'h00000000; sel = 4'hf;
    @(posedge clk); #3;
    rst_n = 1'b0;
    @(posedge clk); #1;
    idle_bus();
    check("midreset_ack", 32'(ack), 32'd0);
    check("midreset_dat_sm", dat_sm, 32'd0);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("postreset_no_response", 32'({ack, err}), 32'd0);
    end
    rd(32'h20, 32'h5A5A5A5A);

    // out-of-range read
`ifdef WSHB_FB_ERR_EN
    single(1'b0, 32'h4000, 32'd0, 4'hf, 1'b1, 32'h5A5A5A5A);
`else
    rd(32'h4000, 32'h01234567);
`endif

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
